rr_dispatcher: RTL and testbench
================================

# rr_dispatcher

Round-robin dispatcher: the distributing counterpart of the round-robin arbiter. It accepts one decoupled input stream and steers each accepted beat to exactly one of N decoupled output lanes, rotating fairly among lanes able to take data. Each lane has a one-entry output register, so all outputs are registered. It sits in front of replicated workers (e.g. N processing lanes) whose results are later merged by the round-robin arbiter.

## Interface
- N_LANES, 4, number of output lanes (power of two, ≥2)
- WIDTH, 8, payload width in bits
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset), sampled on clk
- io_in_valid  in  1  producer has a beat
- io_in_ready  out  1  dispatcher accepts a beat this cycle
- io_in_bits  in  WIDTH  payload
- io_out_k_valid  out  1  lane k holds a beat, for k = 0..N_LANES-1
- io_out_k_ready  in  1  consumer k takes the beat
- io_out_k_bits  out  WIDTH  lane k payload
- io_chosen  out  log2(N_LANES)  lane the current input beat is steered to

## Operation
- State: per lane full_k (1 bit) and data_k (WIDTH); pointer last (log2 N bits), the lane that received the most recent accepted beat.
- Lane k is available when !full_k || io_out_k_ready (drain and refill in the same cycle is allowed).
- Selection (combinational): the lowest-index available lane with index > last; if none, the lowest-index available lane overall. If no lane is available, io_chosen = N_LANES-1 and io_in_ready = 0.
- io_in_ready = OR of all lane-available terms. It does not depend on io_in_valid.
- io_chosen is driven every cycle, whether or not io_in_valid is high.
- Input fire = io_in_valid && io_in_ready. On fire: data_sel <= io_in_bits, full_sel <= 1, last <= sel.
- Output fire on lane k = full_k && io_out_k_ready. On this fire, full_k <= 0, unless lane k is also the selected lane of an input fire, in which case full_k stays 1 and data_k takes the new beat.
- io_out_k_valid = full_k; io_out_k_bits = data_k.
- A beat is never duplicated, dropped or reordered within a lane. Lanes are independent and are never blocked by another lane's stall.
- last does not change without an input fire.

## Timing
- Reset (reset = 0 at a clk edge): every full_k = 0, every data_k = 0, last = 0.
- Reset outputs: every io_out_k_valid = 0, every io_out_k_bits = 0. io_in_ready = 1. io_chosen = 1, because lane 1 is the first lane above last = 0.
- Reset asserted mid-operation discards all held beats on the next edge. Input and output handshakes in that cycle have no effect.
- Latency: a beat accepted at edge t appears on io_out_sel_valid/bits immediately after edge t (one register stage). The earliest consumer take is edge t+1.
- Throughput: one beat per cycle while at least one lane is available. With all consumers always ready, beats rotate 1,2,3,0,1,… after reset.
- Wrap-around: when last = N_LANES-1, the search restarts at lane 0.
- Full condition: all full_k = 1 and all io_out_k_ready = 0 gives io_in_ready = 0. Any single ready re-opens io_in_ready combinationally in the same cycle, and that lane is the one selected.
- No combinational path from io_in_valid to any output. Paths exist from io_out_k_ready to io_in_ready and to io_chosen.

## Test plan
- Reset and rotation: hold reset = 0 for 2 cycles, then release. Keep all io_out_k_ready = 1 and send 0x10,0x11,0x12,0x13,0x14 on consecutive cycles. Required: the beats land on lanes 1,2,3,0,1, each valid one cycle after acceptance, and io_in_ready stays 1 throughout.
- Skip busy lane: lane 2 is full and io_out_2_ready = 0, with last = 1. Send 0xA5. Required: io_chosen = 3, 0xA5 appears on lane 3, and lane 2 still holds its old data.
- Full back-pressure: all io_out_k_ready = 0. Send 4 beats 0x20..0x23, then hold io_in_valid = 1 with 0x24. Required: io_in_ready = 0 after the fourth acceptance and 0x24 is not accepted. Raise only io_out_0_ready for one cycle: required 0x24 is taken into lane 0 in that same cycle, lane 0 shows 0x24 next cycle, and io_in_ready returns to 0.
- Simultaneous drain/refill: lane 1 holds 0x33, io_out_1_ready = 1, and lane 1 is the only available lane. Send 0x44. Required: the consumer receives 0x33, then next cycle lane 1 shows 0x44 with valid held at 1 (no bubble).
- Idle input: io_in_valid = 0 for 10 cycles with all ready. Required: last is unchanged, io_chosen stays constant, and all lanes drain to valid = 0.
- Reset mid-stream: three lanes full, then assert reset for 1 cycle. Required: all io_out_k_valid = 0 and all io_out_k_bits = 0 after the edge, and the next beat after release lands on lane 1.

Source files
------------

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: steers each accepted input beat to one of N one-entry lane registers.
// Latency 1 cycle to lane output; input stalls only when every lane is full and not draining.
module rr_dispatcher #(
  parameter int N_LANES = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [WIDTH-1:0]           io_in_bits,
  output logic                       io_out_0_valid,
  input  logic                       io_out_0_ready,
  output logic [WIDTH-1:0]           io_out_0_bits,
  output logic                       io_out_1_valid,
  input  logic                       io_out_1_ready,
  output logic [WIDTH-1:0]           io_out_1_bits,
  output logic                       io_out_2_valid,
  input  logic                       io_out_2_ready,
  output logic [WIDTH-1:0]           io_out_2_bits,
  output logic                       io_out_3_valid,
  input  logic                       io_out_3_ready,
  output logic [WIDTH-1:0]           io_out_3_bits,
  output logic [$clog2(N_LANES)-1:0] io_chosen
);

  localparam int SEL_W = $clog2(N_LANES);

  logic [N_LANES-1:0] full;
  logic [N_LANES-1:0] out_rdy;
  logic [N_LANES-1:0] avail;
  logic [WIDTH-1:0]   data [N_LANES];
  logic [SEL_W-1:0]   last;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   hi_idx;
  logic [SEL_W-1:0]   lo_idx;
  logic               hi_found;
  logic               lo_found;
  logic               in_fire;

  assign out_rdy = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};

  // A lane draining this cycle can be refilled in the same cycle.
  assign avail = ~full | out_rdy;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (avail[i]) begin
        lo_found = 1'b1;
        lo_idx   = SEL_W'(i);
        if (i > int'(last)) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end
      end
    end
  end

  assign sel         = hi_found ? hi_idx : (lo_found ? lo_idx : SEL_W'(N_LANES - 1));
  assign io_in_ready = |avail;
  assign io_chosen   = sel;
  assign in_fire     = io_in_valid && io_in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= '0;
      last <= '0;
      for (int k = 0; k < N_LANES; k++) begin
        data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_LANES; k++) begin
        if (in_fire && (sel == SEL_W'(k))) begin
          full[k] <= 1'b1;
          data[k] <= io_in_bits;
        end else if (full[k] && out_rdy[k]) begin
          full[k] <= 1'b0;
        end
      end
      if (in_fire) begin
        last <= sel;
      end
    end
  end

  assign io_out_0_valid = full[0];
  assign io_out_1_valid = full[1];
  assign io_out_2_valid = full[2];
  assign io_out_3_valid = full[3];
  assign io_out_0_bits  = data[0];
  assign io_out_1_bits  = data[1];
  assign io_out_2_bits  = data[2];
  assign io_out_3_bits  = data[3];

endmodule

// File: tb/tb_rr_dispatcher.sv
// Bench for rr_dispatcher: queue-free lane model with rotated search plus directed literal checks.
module tb_rr_dispatcher;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_bits = 8'h00;
  logic       in_ready;
  logic [3:0] rdy = 4'hF;
  logic [3:0] vld;
  logic [7:0] ob [4];
  logic [1:0] chosen;

  int n_checks = 0;
  int n_fail = 0;
  bit         m_full [4];
  logic [7:0] m_data [4];
  int         m_last = 0;
  bit         cmp_en = 1'b0;
  logic [7:0] rx_last [4];
  int         lanes [5] = '{1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  rr_dispatcher #(.N_LANES(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready), .io_in_bits(in_bits),
    .io_out_0_valid(vld[0]), .io_out_0_ready(rdy[0]), .io_out_0_bits(ob[0]),
    .io_out_1_valid(vld[1]), .io_out_1_ready(rdy[1]), .io_out_1_bits(ob[1]),
    .io_out_2_valid(vld[2]), .io_out_2_ready(rdy[2]), .io_out_2_bits(ob[2]),
    .io_out_3_valid(vld[3]), .io_out_3_ready(rdy[3]), .io_out_3_bits(ob[3]),
    .io_chosen(chosen)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Lanes visited in rotation order starting just after the last winner.
  function automatic int exp_chosen();
    for (int off = 1; off <= N; off++) begin
      int l;
      l = (m_last + off) % N;
      if (!m_full[l] || rdy[l]) return l;
    end
    return N - 1;
  endfunction

  function automatic bit exp_ready();
    for (int l = 0; l < N; l++) begin
      if (!m_full[l] || rdy[l]) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    int c;
    bit f;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = 8'h00;
      end
      m_last = 0;
    end else begin
      c = exp_chosen();
      f = in_valid && exp_ready();
      for (int k = 0; k < N; k++) begin
        if (vld[k] && rdy[k]) rx_last[k] = ob[k];
        if (f && k == c) begin
          m_full[k] = 1'b1;
          m_data[k] = in_bits;
        end else if (m_full[k] && rdy[k]) begin
          m_full[k] = 1'b0;
        end
      end
      if (f) m_last = c;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("mdl_in_ready", 32'(in_ready), 32'(exp_ready()));
      check("mdl_chosen", 32'(chosen), 32'(exp_chosen()));
      for (int k = 0; k < N; k++) begin
        check($sformatf("mdl_valid%0d", k), 32'(vld[k]), 32'(m_full[k]));
        check($sformatf("mdl_bits%0d", k), 32'(ob[k]), 32'(m_data[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int lane);
    in_valid = 1'b1;
    in_bits  = b;
    #1;
    check($sformatf("sel_%0h", b), 32'(chosen), 32'(lane));
    check($sformatf("rdy_%0h", b), 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check($sformatf("lane_vld_%0h", b), 32'(vld[lane]), 32'd1);
    check($sformatf("lane_bits_%0h", b), 32'(ob[lane]), 32'(b));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    rdy   = 4'hF;
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_chosen", 32'(chosen), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_valid%0d", k), 32'(vld[k]), 32'd0);
      check($sformatf("rst_bits%0d", k), 32'(ob[k]), 32'd0);
    end
    reset = 1'b1;

    // Rotation 1,2,3,0,1 with every consumer ready
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), lanes[i]);

    // Skip a stalled full lane
    rdy = 4'b1011;
    send(8'hB2, 2);
    send(8'hB3, 3);
    send(8'hB0, 0);
    send(8'hB1, 1);
    send(8'hA5, 3);
    check("skip_lane2_vld", 32'(vld[2]), 32'd1);
    check("skip_lane2_bits", 32'(ob[2]), 32'hB2);

    // Full back-pressure
    rdy = 4'hF;
    tick();
    tick();
    rdy = 4'h0;
    send(8'h20, 0);
    send(8'h21, 1);
    send(8'h22, 2);
    send(8'h23, 3);
    in_valid = 1'b1;
    in_bits  = 8'h24;
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_chosen", 32'(chosen), 32'd3);
    tick();
    check("full_lane0_kept", 32'(ob[0]), 32'h20);
    rdy = 4'b0001;
    #1;
    check("reopen_in_ready", 32'(in_ready), 32'd1);
    check("reopen_chosen", 32'(chosen), 32'd0);
    tick();
    rdy = 4'h0;
    in_valid = 1'b0;
    #1;
    check("refill_lane0_vld", 32'(vld[0]), 32'd1);
    check("refill_lane0_bits", 32'(ob[0]), 32'h24);
    check("refull_in_ready", 32'(in_ready), 32'd0);

    // Drain and refill lane 1 without a bubble
    rdy = 4'b0010;
    send(8'h33, 1);
    check("dr_pre_bits", 32'(ob[1]), 32'h33);
    send(8'h44, 1);
    check("dr_consumer_got", 32'(rx_last[1]), 32'h33);

    // Idle input: pointer holds, lanes drain
    rdy = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_chosen", 32'(chosen), 32'd2);
    end
    check("idle_drained", 32'(vld), 32'd0);

    // Reset mid-stream
    rdy = 4'h0;
    send(8'h60, 2);
    send(8'h61, 3);
    send(8'h62, 0);
    reset    = 1'b0;
    rdy      = 4'hF;
    in_valid = 1'b1;
    in_bits  = 8'h99;
    tick();
    reset    = 1'b1;
    in_valid = 1'b0;
    check("mrst_valid", 32'(vld), 32'd0);
    for (int k = 0; k < N; k++) check($sformatf("mrst_bits%0d", k), 32'(ob[k]), 32'd0);
    send(8'h70, 1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
